// File: rtl/repetition_stream_corrector.sv
// Majority-vote decoder for repetition-coded blocks with a one-deep registered output
// stage and saturating per-word / per-bit error statistics.
module repetition_stream_corrector #(
   parameter int DATA_WIDTH    = 8,
   parameter int REPETITION    = 3,
   parameter int COUNTER_WIDTH = 16,
   localparam int BLOCK_WIDTH  = REPETITION * DATA_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     upstream_valid,
   output logic                     upstream_ready,
   input  logic [BLOCK_WIDTH-1:0]   upstream_block,
   output logic                     downstream_valid,
   input  logic                     downstream_ready,
   output logic [DATA_WIDTH-1:0]    downstream_data,
   output logic                     downstream_error,
   input  logic                     counter_clear,
   output logic [COUNTER_WIDTH-1:0] word_error_count,
   output logic [COUNTER_WIDTH-1:0] bit_error_count
);

   localparam int VOTE_W  = $clog2(REPETITION + 1);
   localparam int TALLY_W = $clog2(DATA_WIDTH + 1);
   localparam int SUM_W   = ((COUNTER_WIDTH > TALLY_W) ? COUNTER_WIDTH : TALLY_W) + 1;
   localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

   generate
      if (REPETITION < 3 || (REPETITION % 2) == 0 || DATA_WIDTH < 1 || COUNTER_WIDTH < 1) begin : g_bad_params
         $error("repetition_stream_corrector: REPETITION must be odd and >= 3, widths >= 1");
      end
   endgenerate

   logic [VOTE_W-1:0]     ones [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] vote_data;
   logic [DATA_WIDTH-1:0] disagree;
   logic [TALLY_W-1:0]    tally;
   logic                  error_now;
   logic                  accept;

   // Per bit: count the copies holding a 1; a strict majority wins, any mix is a disagreement.
   always_comb begin
      vote_data = '0;
      disagree  = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ones[i] = '0;
         for (int k = 0; k < REPETITION; k++) begin
            ones[i] = ones[i] + VOTE_W'(upstream_block[k*DATA_WIDTH + i]);
         end
         vote_data[i] = ones[i] > VOTE_W'(REPETITION / 2);
         disagree[i]  = (ones[i] != '0) && (ones[i] != VOTE_W'(REPETITION));
      end
   end

   always_comb begin
      tally = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         tally = tally + TALLY_W'(disagree[i]);
      end
   end

   assign error_now      = |disagree;
   assign upstream_ready = !downstream_valid || downstream_ready;
   assign accept         = upstream_valid && upstream_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         downstream_valid <= 1'b0;
         downstream_data  <= '0;
         downstream_error <= 1'b0;
      end else if (accept) begin
         downstream_valid <= 1'b1;
         downstream_data  <= vote_data;
         downstream_error <= error_now;
      end else if (downstream_ready) begin
         downstream_valid <= 1'b0;
      end
   end

   logic [COUNTER_WIDTH-1:0] word_base, bit_base, word_next, bit_next;
   logic [SUM_W-1:0]         bit_sum;

   // Clear zeroes the base first so a same-cycle block still contributes.
   always_comb begin
      word_base = counter_clear ? '0 : word_error_count;
      bit_base  = counter_clear ? '0 : bit_error_count;
      word_next = word_base;
      bit_next  = bit_base;
      bit_sum   = SUM_W'(bit_base) + SUM_W'(tally);
      if (accept) begin
         if (error_now && (word_base != COUNT_MAX)) begin
            word_next = word_base + COUNTER_WIDTH'(1);
         end
         bit_next = (bit_sum > SUM_W'(COUNT_MAX)) ? COUNT_MAX : bit_sum[COUNTER_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_error_count <= '0;
         bit_error_count  <= '0;
      end else begin
         word_error_count <= word_next;
         bit_error_count  <= bit_next;
      end
   end

endmodule
